// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-to-execute bundle for the ID/EX pipeline register
// master: decode side, drives in_valid/hold/flush and the ID fields, reads EX fields and stall_o
// slave : the pipeline register, reads the ID fields, drives the EX fields, stall_o and bubble_count
interface id_ex_stage_reg_if #(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 4,
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int EX_W    = 3,
    parameter int CNT_W   = 16
);
    logic               in_valid, hold, flush;
    logic [XLEN-1:0]    inst_addr, read_data1, read_data2, imm;
    logic [REG_AW-1:0]  rs1, rs2, rd;
    logic [FUNCT_W-1:0] funct;
    logic [WB_W-1:0]    wb;
    logic [M_W-1:0]     m;
    logic [EX_W-1:0]    ex;
    logic [XLEN-1:0]    inst_addr_out, read_data1_out, read_data2_out, imm_out;
    logic [REG_AW-1:0]  rs1_out, rs2_out, rd_out;
    logic [FUNCT_W-1:0] funct_out;
    logic [WB_W-1:0]    wb_out;
    logic [M_W-1:0]     m_out;
    logic [1:0]         alu_op;
    logic               alu_src, valid_out, stall_o;
    logic [CNT_W-1:0]   bubble_count;

    modport master (
        output in_valid, hold, flush, inst_addr, read_data1, read_data2, imm, rs1, rs2, rd,
               funct, wb, m, ex,
        input  inst_addr_out, read_data1_out, read_data2_out, imm_out, rs1_out, rs2_out, rd_out,
               funct_out, wb_out, m_out, alu_op, alu_src, valid_out, stall_o, bubble_count
    );

    modport slave (
        input  in_valid, hold, flush, inst_addr, read_data1, read_data2, imm, rs1, rs2, rd,
               funct, wb, m, ex,
        output inst_addr_out, read_data1_out, read_data2_out, imm_out, rs1_out, rs2_out, rd_out,
               funct_out, wb_out, m_out, alu_op, alu_src, valid_out, stall_o, bubble_count
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with valid bit, hold, flush, load-use bubble and bubble counter
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, clears every registered output
// bus   : id_ex_stage_reg_if slave; ID fields in, EX fields out, stall_o back to PC and IF/ID
module id_ex_stage_reg #(
    parameter int XLEN        = 64,
    parameter int REG_AW      = 5,
    parameter int FUNCT_W     = 4,
    parameter int WB_W        = 2,
    parameter int M_W         = 3,
    parameter int EX_W        = 3,
    parameter int MEMREAD_BIT = 1,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst_n,
    id_ex_stage_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]    addr_q, rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0]  rs1_q, rs2_q, rd_q;
    logic [FUNCT_W-1:0] funct_q;
    logic [WB_W-1:0]    wb_q, wb_d;
    logic [M_W-1:0]     m_q, m_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_src_q, alu_src_d, valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               haz, bubble, ld_ctl;

    // A load in EX whose destination feeds the instruction in decode; x0 never counts.
    assign haz = valid_q & m_q[MEMREAD_BIT] & bus.in_valid & (rd_q != '0) &
                 ((rd_q == bus.rs1) | (rd_q == bus.rs2));

    always_comb begin
        bubble    = bus.flush | haz;
        ld_ctl    = bus.in_valid & ~bubble;
        valid_d   = ld_ctl;
        wb_d      = ld_ctl ? bus.wb : '0;
        m_d       = ld_ctl ? bus.m : '0;
        alu_op_d  = ld_ctl ? bus.ex[1:0] : 2'b00;
        alu_src_d = ld_ctl ? bus.ex[EX_W-1] : 1'b0;
        cnt_d     = (bubble && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
            wb_q      <= '0;
            m_q       <= '0;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (!bus.hold) begin
            addr_q    <= bus.inst_addr;
            rd1_q     <= bus.read_data1;
            rd2_q     <= bus.read_data2;
            imm_q     <= bus.imm;
            rs1_q     <= bus.rs1;
            rs2_q     <= bus.rs2;
            rd_q      <= bus.rd;
            funct_q   <= bus.funct;
            wb_q      <= wb_d;
            m_q       <= m_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.inst_addr_out  = addr_q;
    assign bus.read_data1_out = rd1_q;
    assign bus.read_data2_out = rd2_q;
    assign bus.imm_out        = imm_q;
    assign bus.rs1_out        = rs1_q;
    assign bus.rs2_out        = rs2_q;
    assign bus.rd_out         = rd_q;
    assign bus.funct_out      = funct_q;
    assign bus.wb_out         = wb_q;
    assign bus.m_out          = m_q;
    assign bus.alu_op         = alu_op_q;
    assign bus.alu_src        = alu_src_q;
    assign bus.valid_out      = valid_q;
    assign bus.stall_o        = haz;
    assign bus.bubble_count   = cnt_q;
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage core, the next generation of the plain ID/EX latch.
- Adds a valid bit, external hold (stall) and flush, and internal load-use hazard detection with bubble insertion.
- Adds a saturating bubble counter for performance debug.
- Sits between decode/register-file read and the EX stage; stall_o feeds back to PC and IF/ID enables.

Parameters:
- XLEN, 64, width of address, register-data and immediate fields
- REG_AW, 5, register-index width
- FUNCT_W, 4, funct field width ({inst[30], inst[14:12]})
- WB_W, 2, WB control bundle width
- M_W, 3, MEM control bundle width
- EX_W, 3, EX control bundle width; must be >= 3
- MEMREAD_BIT, 1, index of MemRead within the M bundle
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage holds a real instruction
- hold  in  1  downstream stall; freeze all state
- flush  in  1  branch/exception squash of the instruction entering EX
- inst_addr / inst_addr_out  in/out  XLEN  PC of instruction
- rs1, rs2 / rs1_out, rs2_out  in/out  REG_AW  source indices
- rd / rd_out  in/out  REG_AW  destination index
- read_data1, read_data2 / read_data1_out, read_data2_out  in/out  XLEN  operands
- imm / imm_out  in/out  XLEN  sign-extended immediate
- funct / funct_out  in/out  FUNCT_W  ALU-control funct bits
- wb / wb_out  in/out  WB_W  writeback controls
- m / m_out  in/out  M_W  memory controls
- ex  in  EX_W  execute controls
- alu_op  out  2  registered ex[1:0]
- alu_src  out  1  registered ex[EX_W-1]
- valid_out  out  1  EX-stage entry is a real instruction
- stall_o  out  1  combinational load-use stall request to PC and IF/ID
- bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, bubble_count is 0. It overrides all other inputs. Release takes effect at the first clk edge with rst_n high.
- Hazard detect is combinational: haz = valid_out & m_out[MEMREAD_BIT] & in_valid & (rd_out != 0) & ((rd_out == rs1) | (rd_out == rs2)).
- stall_o = haz, independent of hold and flush.
- Per-edge priority, highest first:
  - 1. hold=1: all registers keep their values, including valid_out and bubble_count. haz stays visible on stall_o.
  - 2. flush=1: valid_out, wb_out, m_out, alu_op and alu_src go to 0. Data fields (addr, indices, operands, imm, funct) load from inputs. bubble_count increments.
  - 3. haz=1: bubble. Control fields and valid_out go to 0. Data fields load from inputs (don't-care). bubble_count increments.
  - 4. Otherwise, normal load: all fields load from inputs, valid_out <= in_valid. If in_valid=0, control fields load as 0 instead of the inputs.
- Invariant: valid_out=0 implies wb_out, m_out, alu_op and alu_src are all 0.
- rd_out always captures rd. No stale-hold of rd.
- Latency: one cycle from inputs to outputs; there is no bypass path.
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Simultaneous flush and haz: flush wins; the counter increments once.
- rd_out = 0 never raises a hazard (x0 is hardwired).
- A back-to-back dependent load after a bubble produces no second hazard, because the bubble entry has valid_out=0.
- Reset asserted mid-hold or mid-bubble: outputs clear immediately, with no dependency on clk.

Test Plan:
- Reset: drive all inputs to nonzero, assert rst_n=0 between edges -> every output reads 0 immediately; after release, first edge with in_valid=1, rd=7, wb=2'b11 -> rd_out=7, wb_out=2'b11, valid_out=1.
- Load-use: cycle N loads m=3'b010 (MemRead), rd=5, valid; cycle N+1 presents rs1=5, in_valid=1 -> stall_o=1 during N+1; at edge N+1 valid_out=0, m_out=0, alu_op=0, bubble_count=1; next cycle stall_o=0.
- No hazard on x0 or a non-load: rd_out=0 with MemRead and rs2=0 -> stall_o=0. rd_out=5 with m_out[1]=0 and rs1=5 -> stall_o=0, normal load.
- Hold: hold=1 for 3 cycles while inputs change (inst_addr 0x100→0x104→0x108) -> inst_addr_out stays at its prior value 0xFC and bubble_count is unchanged; release -> loads 0x108.
- Flush over hazard: flush=1 with haz=1, ex=3'b110 -> valid_out=0, alu_src=0, alu_op=0; bubble_count increments by exactly 1.
- Saturation: CNT_W=2, force 5 consecutive flushes -> bubble_count sequence 1,2,3,3,3.
